pingpong_frame_buf: RTL

Parametrised double-buffered (ping-pong) frame store between a pixel-stream source and a 2D filter operator. Captures one IMG_W×IMG_H frame per bank from a strobed input stream and hands each completed bank to the operator with a one-cycle `start` pulse. The operator reads the bank randomly and releases it with `op_done`, so capture of the next frame overlaps processing of the current one. Frames that arrive with no free bank are dropped whole and flagged; they are never partially written.

---
 rtl/filter2d_pkg.sv | 31 +++
 rtl/sdp_ram.sv | 36 +++
 rtl/pingpong_frame_buf.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/filter2d_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// filter2d_pkg : shared state encodings and default frame geometry for the 2D
//                filter path.                                    Rev 1.0
// ---------------------------------------------------------------------------
package filter2d_pkg;

  typedef enum logic [1:0] {
    EMPTY   = 2'd0,
    FILLING = 2'd1,
    FULL    = 2'd2,
    READING = 2'd3
  } bank_state_t;

  typedef enum logic [1:0] {
    SEEK  = 2'd0,
    WRITE = 2'd1,
    DROP  = 2'd2
  } wr_state_t;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } rd_state_t;

  localparam int DEF_DW    = 8;
  localparam int DEF_IMG_W = 256;
  localparam int DEF_IMG_H = 256;

endpackage
`default_nettype wire

// File: rtl/sdp_ram.sv
`default_nettype none
// ---------------------------------------------------------------------------
// sdp_ram : simple dual-port RAM, one synchronous write and one registered
//           read port with enable (output holds when not reading). Rev 1.0
// ---------------------------------------------------------------------------
module sdp_ram #(
  parameter  int DW    = 8,
  parameter  int DEPTH = 256,
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          wr_en_i,
  input  logic [AW-1:0] wr_addr_i,
  input  logic [DW-1:0] wr_data_i,
  input  logic          rd_en_i,
  input  logic [AW-1:0] rd_addr_i,
  output logic [DW-1:0] rd_data_o
);

  logic [DW-1:0] mem_q [DEPTH];
  logic [DW-1:0] rd_data_q;

  always_ff @(posedge clk) begin
    if (wr_en_i) mem_q[wr_addr_i] <= wr_data_i;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)     rd_data_q <= '0;
    else if (rd_en_i) rd_data_q <= mem_q[rd_addr_i];
  end

  assign rd_data_o = rd_data_q;

endmodule
`default_nettype wire

// File: rtl/pingpong_frame_buf.sv
`default_nettype none
// ---------------------------------------------------------------------------
// pingpong_frame_buf : two-bank frame store; captures a raster stream into a
//                      free bank and hands full banks to a random-access reader.
// Rev 1.0
// ---------------------------------------------------------------------------
module pingpong_frame_buf
  import filter2d_pkg::*;
#(
  parameter  int DW    = DEF_DW,
  parameter  int IMG_W = DEF_IMG_W,
  parameter  int IMG_H = DEF_IMG_H,
  localparam int NPIX  = IMG_W * IMG_H,
  localparam int AW    = $clog2(NPIX)
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          i_strb,
  input  logic [DW-1:0] i_data,
  output logic          start,
  input  logic          mem_rd,
  input  logic [AW-1:0] rd_addr,
  output logic [DW-1:0] rd_data,
  input  logic          op_done,
  input  logic          ovf_clr,
  output logic          o_overflow,
  output logic          o_busy
);

  localparam logic [AW-1:0] LAST_PIX = AW'(NPIX - 1);

  bank_state_t   bank_q [2];
  bank_state_t   bank_d [2];
  wr_state_t     wr_state_q, wr_state_d;
  rd_state_t     rd_state_q, rd_state_d;
  logic [AW-1:0] wr_cnt_q, wr_cnt_d;
  logic          wr_bank_q, wr_bank_d;
  logic          wr_sel_q, wr_sel_d;
  logic          rd_bank_q, rd_bank_d;
  logic          rd_sel_q;
  logic          start_q, start_d;
  logic          ovf_q, ovf_d;

  logic          release_w;
  logic [1:0]    free_w;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic          rd_en;
  logic [DW-1:0] bank_rd [2];

  always_comb begin
    bank_d     = bank_q;
    wr_state_d = wr_state_q;
    wr_cnt_d   = wr_cnt_q;
    wr_bank_d  = wr_bank_q;
    wr_sel_d   = wr_sel_q;
    rd_state_d = rd_state_q;
    rd_bank_d  = rd_bank_q;
    start_d    = 1'b0;
    ovf_d      = ovf_q & ~ovf_clr;
    wr_en      = 1'b0;
    wr_addr    = wr_cnt_q;

    // A bank released this cycle is already usable by the writer.
    release_w = (rd_state_q == BUSY) && op_done;
    free_w[0] = (bank_q[0] == EMPTY) || (release_w && (rd_bank_q == 1'b0));
    free_w[1] = (bank_q[1] == EMPTY) || (release_w && (rd_bank_q == 1'b1));
    if (release_w) bank_d[rd_bank_q] = EMPTY;

    case (wr_state_q)
      SEEK: begin
        if (i_strb) begin
          wr_cnt_d = AW'(1);
          if (free_w[wr_bank_q] || free_w[~wr_bank_q]) begin
            wr_sel_d         = free_w[wr_bank_q] ? wr_bank_q : ~wr_bank_q;
            bank_d[wr_sel_d] = FILLING;
            wr_en            = 1'b1;
            wr_addr          = '0;
            wr_state_d       = WRITE;
          end else begin
            ovf_d      = 1'b1;
            wr_state_d = DROP;
          end
        end
      end
      WRITE: begin
        if (i_strb) begin
          wr_en = 1'b1;
          if (wr_cnt_q == LAST_PIX) begin
            bank_d[wr_sel_q] = FULL;
            wr_bank_d        = ~wr_bank_q;
            wr_cnt_d         = '0;
            wr_state_d       = SEEK;
          end else begin
            wr_cnt_d = wr_cnt_q + AW'(1);
          end
        end
      end
      DROP: begin
        if (i_strb) begin
          if (wr_cnt_q == LAST_PIX) begin
            wr_cnt_d   = '0;
            wr_state_d = SEEK;
          end else begin
            wr_cnt_d = wr_cnt_q + AW'(1);
          end
        end
      end
      default: wr_state_d = SEEK;
    endcase

    // Looking at bank_d lets a bank finishing this cycle go straight to READING.
    if (rd_state_q == IDLE) begin
      if (bank_d[rd_bank_q] == FULL) begin
        rd_bank_d = rd_bank_q;
        start_d   = 1'b1;
      end else if (bank_d[~rd_bank_q] == FULL) begin
        rd_bank_d = ~rd_bank_q;
        start_d   = 1'b1;
      end
    end else if (release_w) begin
      if (bank_d[~rd_bank_q] == FULL) begin
        rd_bank_d = ~rd_bank_q;
        start_d   = 1'b1;
      end else begin
        rd_state_d = IDLE;
      end
    end
    if (start_d) begin
      bank_d[rd_bank_d] = READING;
      rd_state_d        = BUSY;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bank_q[0]  <= EMPTY;
      bank_q[1]  <= EMPTY;
      wr_state_q <= SEEK;
      rd_state_q <= IDLE;
      wr_cnt_q   <= '0;
      wr_bank_q  <= 1'b0;
      wr_sel_q   <= 1'b0;
      rd_bank_q  <= 1'b0;
      rd_sel_q   <= 1'b0;
      start_q    <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      bank_q     <= bank_d;
      wr_state_q <= wr_state_d;
      rd_state_q <= rd_state_d;
      wr_cnt_q   <= wr_cnt_d;
      wr_bank_q  <= wr_bank_d;
      wr_sel_q   <= wr_sel_d;
      rd_bank_q  <= rd_bank_d;
      start_q    <= start_d;
      ovf_q      <= ovf_d;
      if (rd_en) rd_sel_q <= rd_bank_q;
    end
  end

  assign rd_en = mem_rd && (rd_state_q == BUSY);

  for (genvar b = 0; b < 2; b++) begin : g_bank
    sdp_ram #(
      .DW    (DW),
      .DEPTH (NPIX)
    ) u_ram (
      .clk       (clk),
      .reset_n   (reset_n),
      .wr_en_i   (wr_en && (wr_sel_d == 1'(b))),
      .wr_addr_i (wr_addr),
      .wr_data_i (i_data),
      .rd_en_i   (rd_en && (rd_bank_q == 1'(b))),
      .rd_addr_i (rd_addr),
      .rd_data_o (bank_rd[b])
    );
  end

  assign start      = start_q;
  assign rd_data    = bank_rd[rd_sel_q];
  assign o_overflow = ovf_q;
  assign o_busy     = (rd_state_q == BUSY);

endmodule
`default_nettype wire
